vga_timing_ctrl: RTL and testbench

Frame timing controller for the Basys VGA output path. It divides the system clock down to a pixel strobe and runs the horizontal and vertical pixel counters. From these it generates hblank/vblank, which drive the downstream RGB visibility gating, and hsync/vsync, which go to the connector. It also exports pixel coordinates and line/frame start strobes for pixel generators.

---
 rtl/vga_timing_ctrl.sv | 156 +++++++++++++++
 tb/tb_vga_timing_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_ctrl
// Description : VGA frame timing controller. Divides the system clock down to
//               a pixel strobe, runs the horizontal/vertical pixel counters
//               and produces registered blanking, sync, coordinate and
//               line/frame start outputs.
// Ports       : clk, rst_n (async, active low), en (run enable)
//               pix_ce      - one-clk strobe, new pixel outputs valid
//               hblank/vblank, hsync/vsync (level per SYNC_POL)
//               x [XW-1:0], y [YW-1:0] - pixel coordinates
//               line_start, frame_start - start strobes
//               frame_cnt [7:0] - only when VGA_FRAME_CNT_EN is defined
// Options     : `define VGA_FRAME_CNT_EN adds the frame_cnt output.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_ctrl #(
    parameter int CLK_DIV  = 4,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int SYNC_POL = 0,
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int XW      = $clog2(H_TOTAL),
    localparam int YW      = $clog2(V_TOTAL)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    output logic          pix_ce,
    output logic          hblank,
    output logic          vblank,
    output logic          hsync,
    output logic          vsync,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          line_start,
    output logic          frame_start
`ifdef VGA_FRAME_CNT_EN
    ,
    output logic [7:0]    frame_cnt
`endif
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [XW-1:0] X_LAST   = XW'(H_TOTAL - 1);
    localparam logic [YW-1:0] Y_LAST   = YW'(V_TOTAL - 1);

    // Sync window bounds kept 32 bits wide so an end bound equal to a power
    // of two cannot wrap inside the counter width.
    localparam int unsigned HS_BEG = H_ACTIVE + H_FP;
    localparam int unsigned HS_END = H_ACTIVE + H_FP + H_SYNC;
    localparam int unsigned VS_BEG = V_ACTIVE + V_FP;
    localparam int unsigned VS_END = V_ACTIVE + V_FP + V_SYNC;

    localparam logic SYNC_ACT = (SYNC_POL != 0);

    logic [DW-1:0] div_cnt_q, div_cnt_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic          pix_ce_q, line_start_q, frame_start_q;
    logic          hblank_q, vblank_q, hsync_q, vsync_q;
    logic          advance;
    logic          hblank_d, vblank_d, hsync_d, vsync_d;
    logic          line_start_d, frame_start_d;

    // Next-state counters. When en is low every _d equals its _q, so the
    // decoded levels below naturally hold as well.
    always_comb begin
        advance   = en && (div_cnt_q == DIV_LAST);
        div_cnt_d = div_cnt_q;
        x_d       = x_q;
        y_d       = y_q;
        if (en) begin
            div_cnt_d = advance ? '0 : div_cnt_q + 1'b1;
        end
        if (advance) begin
            x_d = (x_q == X_LAST) ? '0 : x_q + 1'b1;
            if (x_q == X_LAST) begin
                y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
            end
        end
    end

    // Decode from the next-state counters so the registered levels are
    // aligned with the registered x/y.
    always_comb begin
        hblank_d      = (32'(x_d) >= 32'(H_ACTIVE));
        vblank_d      = (32'(y_d) >= 32'(V_ACTIVE));
        hsync_d       = ((32'(x_d) >= HS_BEG) && (32'(x_d) < HS_END)) ? SYNC_ACT : !SYNC_ACT;
        vsync_d       = ((32'(y_d) >= VS_BEG) && (32'(y_d) < VS_END)) ? SYNC_ACT : !SYNC_ACT;
        line_start_d  = advance && (x_d == '0);
        frame_start_d = advance && (x_d == '0) && (y_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q     <= '0;
            x_q           <= X_LAST;
            y_q           <= Y_LAST;
            hblank_q      <= 1'b1;
            vblank_q      <= 1'b1;
            hsync_q       <= !SYNC_ACT;
            vsync_q       <= !SYNC_ACT;
            pix_ce_q      <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            div_cnt_q     <= div_cnt_d;
            x_q           <= x_d;
            y_q           <= y_d;
            hblank_q      <= hblank_d;
            vblank_q      <= vblank_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            pix_ce_q      <= advance;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

`ifdef VGA_FRAME_CNT_EN
    logic [7:0] frame_cnt_q;

    // Counts on the same edge that raises frame_start; wraps 255 -> 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q <= 8'd0;
        end else if (frame_start_d) begin
            frame_cnt_q <= frame_cnt_q + 8'd1;
        end
    end

    assign frame_cnt = frame_cnt_q;
`endif

    assign pix_ce      = pix_ce_q;
    assign hblank      = hblank_q;
    assign vblank      = vblank_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign x           = x_q;
    assign y           = y_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_timing_ctrl
// Description : Directed self-checking bench for vga_timing_ctrl using a
//               small 8x6 frame (4x3 active) and a divide-by-2 pixel clock.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_timing_ctrl;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       pix_ce, hblank, vblank, hsync, vsync, line_start, frame_start;
    logic [2:0] x;
    logic [2:0] y;
`ifdef VGA_FRAME_CNT_EN
    logic [7:0] frame_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int t0;
    int ex, ey;

    vga_timing_ctrl #(
        .CLK_DIV (2),
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .SYNC_POL(0)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .pix_ce     (pix_ce),
        .hblank     (hblank),
        .vblank     (vblank),
        .hsync      (hsync),
        .vsync      (vsync),
        .x          (x),
        .y          (y),
        .line_start (line_start),
        .frame_start(frame_start)
`ifdef VGA_FRAME_CNT_EN
        ,
        .frame_cnt  (frame_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b1;
        repeat (3) @(negedge clk);

        // Reset values
        chk("rst_x",      32'(x), 32'd7);
        chk("rst_y",      32'(y), 32'd5);
        chk("rst_hblank", 32'(hblank), 32'd1);
        chk("rst_vblank", 32'(vblank), 32'd1);
        chk("rst_hsync",  32'(hsync), 32'd1);
        chk("rst_vsync",  32'(vsync), 32'd1);
        chk("rst_pix_ce", 32'(pix_ce), 32'd0);
        chk("rst_fstart", 32'(frame_start), 32'd0);
`ifdef VGA_FRAME_CNT_EN
        chk("rst_fcnt",   32'(frame_cnt), 32'd0);
`endif

        // Start-up: (0,0) two clocks after release
        rst_n = 1'b1;
        @(negedge clk);
        chk("st_pix_ce0", 32'(pix_ce), 32'd0);
        @(negedge clk);
        t0 = cyc;
        chk("st_pix_ce",  32'(pix_ce), 32'd1);
        chk("st_fstart",  32'(frame_start), 32'd1);
        chk("st_lstart",  32'(line_start), 32'd1);
        chk("st_x",       32'(x), 32'd0);
        chk("st_y",       32'(y), 32'd0);
        chk("st_hblank",  32'(hblank), 32'd0);
        chk("st_vblank",  32'(vblank), 32'd0);
        chk("st_hsync",   32'(hsync), 32'd1);
        chk("st_vsync",   32'(vsync), 32'd1);
`ifdef VGA_FRAME_CNT_EN
        chk("st_fcnt",    32'(frame_cnt), 32'd1);
`endif

        // Full frame, pixel by pixel, ending on the next frame's (0,0)
        for (int k = 1; k <= 48; k++) begin
            @(negedge clk);
            chk("gap_pix_ce", 32'(pix_ce), 32'd0);
            @(negedge clk);
            ex = k % 8;
            ey = (k / 8) % 6;
            chk("fr_pix_ce", 32'(pix_ce), 32'd1);
            chk("fr_x",      32'(x), 32'(ex));
            chk("fr_y",      32'(y), 32'(ey));
            chk("fr_hblank", 32'(hblank), 32'(ex >= 4));
            chk("fr_vblank", 32'(vblank), 32'(ey >= 3));
            chk("fr_hsync",  32'(hsync), 32'(!(ex == 5 || ex == 6)));
            chk("fr_vsync",  32'(vsync), 32'(ey != 4));
            chk("fr_lstart", 32'(line_start), 32'(ex == 0));
            chk("fr_fstart", 32'(frame_start), 32'(ex == 0 && ey == 0));
        end
        chk("frame_period", 32'(cyc - t0), 32'd96);

        // Pause at (2,1)
        repeat (20) @(negedge clk);
        chk("pre_en_x", 32'(x), 32'd2);
        chk("pre_en_y", 32'(y), 32'd1);
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("en0_pix_ce", 32'(pix_ce), 32'd0);
            chk("en0_x",      32'(x), 32'd2);
            chk("en0_y",      32'(y), 32'd1);
            chk("en0_hblank", 32'(hblank), 32'd0);
            chk("en0_hsync",  32'(hsync), 32'd1);
        end
        en = 1'b1;
        @(negedge clk);
        chk("re_pix_ce0", 32'(pix_ce), 32'd0);
        chk("re_x0",      32'(x), 32'd2);
        @(negedge clk);
        chk("re_pix_ce",  32'(pix_ce), 32'd1);
        chk("re_x",       32'(x), 32'd3);
        chk("re_y",       32'(y), 32'd1);

        // Move to (6,4): pixel index 11 -> 38
        repeat (54) @(negedge clk);
        chk("pr_x",      32'(x), 32'd6);
        chk("pr_y",      32'(y), 32'd4);
        chk("pr_hsync",  32'(hsync), 32'd0);
        chk("pr_vsync",  32'(vsync), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_x",      32'(x), 32'd7);
        chk("ar_y",      32'(y), 32'd5);
        chk("ar_hblank", 32'(hblank), 32'd1);
        chk("ar_vblank", 32'(vblank), 32'd1);
        chk("ar_hsync",  32'(hsync), 32'd1);
        chk("ar_vsync",  32'(vsync), 32'd1);
        chk("ar_pix_ce", 32'(pix_ce), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rr_pix_ce0", 32'(pix_ce), 32'd0);
        @(negedge clk);
        chk("rr_fstart",  32'(frame_start), 32'd1);
        chk("rr_x",       32'(x), 32'd0);
        chk("rr_y",       32'(y), 32'd0);

`ifdef VGA_FRAME_CNT_EN
        chk("fc_1", 32'(frame_cnt), 32'd1);
        for (int f = 2; f <= 3; f++) begin
            repeat (96) @(negedge clk);
            chk("fc_fstart", 32'(frame_start), 32'd1);
            chk("fc_n",      32'(frame_cnt), 32'(f));
        end
        repeat (252 * 96) @(negedge clk);
        chk("fc_255", 32'(frame_cnt), 32'd255);
        repeat (96) @(negedge clk);
        chk("fc_wrap_fs", 32'(frame_start), 32'd1);
        chk("fc_wrap",    32'(frame_cnt), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
